lms_spi_responder: RTL and testbench
====================================

LMS_SPI_RESPONDER -- requirements
Module: lms_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sen, sclk and mosi; legal range 2-4.
REQ-002 SHALL have parameter MISO_IDLE, default 1'b0: miso level whenever miso_oe is 0.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sen, input, 1: SPI chip select, active low, asynchronous to clk.
REQ-006 SHALL have port sclk, input, 1: SPI clock, asynchronous to clk.
REQ-007 SHALL have port mosi, input, 1: SPI data from master, MSB first.
REQ-008 SHALL have port miso, output, 1: SPI read data to master.
REQ-009 SHALL have port miso_oe, output, 1: miso output enable.
REQ-010 SHALL have port wr_stb, output, 1: one-cycle pulse when a register write completes.
REQ-011 SHALL have port wr_addr, output, 7: address of the last write.
REQ-012 SHALL have port wr_data, output, 8: data of the last write.
REQ-013 SHALL have port lcl_addr, input, 7: local read-back address.
REQ-014 SHALL have port lcl_dout, output, 8: regfile[lcl_addr], registered, 1-cycle latency.
REQ-015 SHALL have port frame_err, output, 1: one-cycle pulse when sen rises before bit 16.

Function
REQ-016 SHALL implement an LMS6002D-style 16-bit frame: bit15 = W/nR (1 = write), bits14:8 = address, bits7:0 = data.
REQ-017 SHALL hold a 128 x 8 register file, written only through SPI write frames.
REQ-018 SHALL pass sen, sclk and mosi through SYNC_STAGES flops; reset value is 1 for sen and 0 for sclk and mosi.
REQ-019 SHALL detect edges from the last two synchronized samples.
REQ-020 SHALL use states IDLE, CMD, DATA and DONE.
REQ-021 IDLE -> CMD on a synchronized sen falling edge; the bit counter clears to 0.
REQ-022 In CMD, SHALL shift mosi into the command register on each sclk rising edge; after the 8th edge, latch rw and addr and go to DATA.
REQ-023 On entering DATA with rw = 0, SHALL load shadow <= regfile[addr].
REQ-024 For a read, SHALL assert miso_oe from the first sclk falling edge in DATA until frame end.
REQ-025 For a read, on each sclk falling edge in DATA, miso SHALL present shadow[7], then shadow[6], and so on, so the master samples on rising edges.
REQ-026 In DATA, SHALL shift mosi on each sclk rising edge.
REQ-027 On the 8th DATA rising edge (bit 16) with rw = 1: regfile[addr] <= data, wr_addr and wr_data update, and wr_stb pulses for one cycle in the same clk cycle.
REQ-028 After bit 16, the state SHALL go to DONE.
REQ-029 DONE SHALL ignore all sclk edges and SHALL NOT set frame_err.
REQ-030 DONE -> IDLE on a synchronized sen rising edge.
REQ-031 A sen rising edge in CMD or DATA SHALL pulse frame_err, discard the frame with no regfile write, and return to IDLE.
REQ-032 A simultaneous sen rise and 16th sclk rise in one clk cycle SHALL be treated as frame abort (REQ-031).
REQ-033 A sen rising edge SHALL force miso_oe = 0 and miso = MISO_IDLE in the same cycle.
REQ-034 Latency: wr_stb SHALL assert SYNC_STAGES+1 clk cycles after the 16th sclk rising edge at the pin.
REQ-035 Operation is guaranteed only when sclk high and low phases are each >= SYNC_STAGES+2 clk periods.
REQ-036 A local read of an address SHALL return the new value starting the cycle after wr_stb for that address.

Reset
REQ-037 On rst_n = 0, SHALL immediately force: state IDLE, all regfile entries 0x00, miso = MISO_IDLE, miso_oe = 0, wr_stb = 0, frame_err = 0, wr_addr = 0, wr_data = 0, lcl_dout = 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no write and no frame_err.
REQ-039 If sen is already low at reset release, the block SHALL stay in IDLE until sen rises and falls again.

Verification
REQ-040 Write frame 0x85A5 -> wr_stb pulses once, wr_addr = 0x05, wr_data = 0xA5; lcl_addr = 5 then returns lcl_dout = 0xA5.
REQ-041 Write 0x85A5, then read frame 0x0500 -> miso bits sampled on sclk rising edges 9-16 = 1,0,1,0,0,1,0,1; miso_oe = 1 only during the data phase; no wr_stb.
REQ-042 sen rises after 12 bits of 0x9F3C -> frame_err pulses once, no wr_stb, lcl_addr = 0x1F returns 0x00.
REQ-043 20 sclk pulses on write 0x8211 -> exactly one wr_stb with data 0x11; no frame_err.
REQ-044 rst_n pulsed low during bit 10 of write 0x8477 -> no wr_stb, regfile[4] = 0x00; the next clean frame 0x8477 succeeds.
REQ-045 Read of addr 0x7F after reset -> miso = 0 for all 8 data bits; the frame ends with miso_oe = 0 and miso = MISO_IDLE.

Source files
------------

// File: rtl/lms_spi_responder.sv
// LMS6002D-style SPI register responder: 16-bit frames (W/nR, addr7, data8)
// into a 128x8 register file, with sen/sclk/mosi oversampled on clk.
module lms_spi_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sen,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [6:0] lcl_addr,
  output logic [7:0] lcl_dout,
  output logic       frame_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [SYNC_STAGES-1:0] sen_sq, sclk_sq, mosi_sq;
  logic                   sen_pq, sclk_pq;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   armed_q;

  logic sen_s, sclk_s, mosi_s;
  logic sen_rise, sen_fall, sclk_rise, sclk_fall;

  assign sen_s     = sen_sq[SYNC_STAGES-1];
  assign sclk_s    = sclk_sq[SYNC_STAGES-1];
  assign mosi_s    = mosi_sq[SYNC_STAGES-1];
  assign sen_rise  = sen_s & ~sen_pq;
  assign sen_fall  = ~sen_s & sen_pq & armed_q;
  assign sclk_rise = sclk_s & ~sclk_pq;
  assign sclk_fall = ~sclk_s & sclk_pq;

  // armed_q only sets once sen is seen high through a fully refilled
  // synchronizer, so a sen held low across reset never starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sen_sq  <= '1;
      sclk_sq <= '0;
      mosi_sq <= '0;
      sen_pq  <= 1'b1;
      sclk_pq <= 1'b0;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sen_sq  <= {sen_sq[SYNC_STAGES-2:0], sen};
      sclk_sq <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      mosi_sq <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      sen_pq  <= sen_s;
      sclk_pq <= sclk_s;
      vld_q   <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      armed_q <= armed_q | (vld_q[SYNC_STAGES] & sen_s & sen_pq);
    end
  end

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, sr_nxt;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] shadow_q, shadow_d;
  logic       oe_q, oe_d;
  logic       miso_q, miso_d;
  logic       wr_stb_q, wr_stb_d;
  logic       ferr_q, ferr_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rf_we;
  logic [7:0] rf_q [128];
  logic [7:0] lcl_dout_q;

  assign sr_nxt = {sr_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    oe_d      = oe_q;
    miso_d    = miso_q;
    wr_stb_d  = 1'b0;
    ferr_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rf_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        oe_d   = 1'b0;
        miso_d = MISO_IDLE;
        if (sen_fall) begin
          state_d = CMD;
          cnt_d   = 3'd0;
        end
      end
      CMD: begin
        if (sen_rise) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (sclk_rise) begin
          sr_d  = sr_nxt;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d  = DATA;
            cnt_d    = 3'd0;
            rw_d     = sr_nxt[7];
            addr_d   = sr_nxt[6:0];
            shadow_d = rf_q[sr_nxt[6:0]];
          end
        end
      end
      DATA: begin
        // Abort wins over a coincident 16th sclk edge.
        if (sen_rise) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          oe_d    = 1'b0;
          miso_d  = MISO_IDLE;
        end else if (sclk_fall && !rw_q) begin
          oe_d     = 1'b1;
          miso_d   = shadow_q[7];
          shadow_d = {shadow_q[6:0], 1'b0};
        end else if (sclk_rise) begin
          sr_d  = sr_nxt;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = DONE;
            if (rw_q) begin
              rf_we     = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = sr_nxt;
            end
          end
        end
      end
      DONE: begin
        if (sen_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = MISO_IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      shadow_q  <= '0;
      oe_q      <= 1'b0;
      miso_q    <= MISO_IDLE;
      wr_stb_q  <= 1'b0;
      ferr_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      shadow_q  <= shadow_d;
      oe_q      <= oe_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      ferr_q    <= ferr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) rf_q[i] <= '0;
      lcl_dout_q <= '0;
    end else begin
      if (rf_we) rf_q[addr_q] <= sr_nxt;
      lcl_dout_q <= rf_q[lcl_addr];
    end
  end

  assign miso_oe   = oe_q & ~sen_rise;
  assign miso      = miso_oe ? miso_q : MISO_IDLE;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign lcl_dout  = lcl_dout_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_lms_spi_responder.sv
// Bench for lms_spi_responder: directed frames plus random
// write/read/abort frames against a 128-byte register model.
module tb_lms_spi_responder;
  localparam int S = 2;
  localparam int H = 6;

  logic clk = 0, rst_n = 0, sen = 1, sclk = 0, mosi = 0;
  logic miso, miso_oe, wr_stb, frame_err;
  logic [6:0] wr_addr;
  logic [6:0] lcl_addr = '0;
  logic [7:0] wr_data, lcl_dout;

  int errs = 0, checks = 0;
  int cyc = 0, stb_cnt = 0, ferr_cnt = 0, stb_cyc = 0, rise_cyc = 0;
  int b_stb, b_ferr;
  logic [6:0] last_wa = '0;
  logic [7:0] last_wd = '0, post_dout = '0;
  logic stb_prev = 0;
  logic [7:0] rd;
  logic oe_cmd, oe_all;
  logic [7:0] mem [128];

  lms_spi_responder #(.SYNC_STAGES(S), .MISO_IDLE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sen(sen), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .lcl_addr(lcl_addr),
    .lcl_dout(lcl_dout), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (stb_prev) post_dout = lcl_dout;
    stb_prev = wr_stb;
    if (wr_stb) begin
      stb_cnt++;
      stb_cyc = cyc;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_clr();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic lread(input logic [6:0] a, output logic [7:0] v);
    lcl_addr = a;
    @(negedge clk);
    v = lcl_dout;
  endtask

  task automatic bits(input logic [15:0] w, input int n,
                      input bit simul, input int rst_at);
    oe_cmd = 0;
    oe_all = 1;
    rd = '0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
      end
      mosi = (i < 16) ? w[15-i] : 1'b0;
      repeat (H) @(negedge clk);
      if (i < 8) oe_cmd |= miso_oe;
      else if (i < 16) begin
        rd[15-i] = miso;
        oe_all &= miso_oe;
      end
      sclk = 1;
      if (i == 15) rise_cyc = cyc;
      if (simul && i == n - 1) sen = 1;
      repeat (H) @(negedge clk);
      sclk = 0;
    end
  endtask

  task automatic frame(input logic [15:0] w, input int n,
                       input bit simul, input int rst_at);
    b_stb = stb_cnt;
    b_ferr = ferr_cnt;
    sen = 0;
    repeat (H) @(negedge clk);
    bits(w, n, simul, rst_at);
    repeat (H) @(negedge clk);
    sen = 1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic chk_write(input string t, input logic [6:0] a,
                           input logic [7:0] d);
    chk({t, "_stb"}, stb_cnt - b_stb, 1);
    chk({t, "_ferr"}, ferr_cnt - b_ferr, 0);
    chk({t, "_addr"}, last_wa, a);
    chk({t, "_data"}, last_wd, d);
    chk({t, "_lat"}, stb_cyc - rise_cyc, S + 1);
    chk({t, "_post"}, post_dout, d);
  endtask

  logic [7:0] v;

  initial begin
    mem_clr();
    repeat (3) @(negedge clk);
    chk("rst_oe", miso_oe, 0);
    chk("rst_stb", wr_stb, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_dout", lcl_dout, 0);

    lcl_addr = 7'h05;
    frame(16'h85A5, 16, 0, -1);
    chk_write("w85A5", 7'h05, 8'hA5);
    mem[5] = 8'hA5;
    lread(7'h05, v);
    chk("lread5", v, 8'hA5);

    frame(16'h0500, 16, 0, -1);
    chk("r05_data", rd, 8'hA5);
    chk("r05_oecmd", oe_cmd, 0);
    chk("r05_oedata", oe_all, 1);
    chk("r05_stb", stb_cnt - b_stb, 0);
    chk("r05_oe_end", miso_oe, 0);

    frame(16'h9F3C, 12, 0, -1);
    chk("abort12_ferr", ferr_cnt - b_ferr, 1);
    chk("abort12_stb", stb_cnt - b_stb, 0);
    lread(7'h1F, v);
    chk("abort12_rf", v, 8'h00);

    lcl_addr = 7'h02;
    frame(16'h8211, 20, 0, -1);
    chk_write("w20", 7'h02, 8'h11);
    mem[2] = 8'h11;

    frame(16'h8C5A, 16, 1, -1);
    chk("simul_ferr", ferr_cnt - b_ferr, 1);
    chk("simul_stb", stb_cnt - b_stb, 0);
    lread(7'h0C, v);
    chk("simul_rf", v, 8'h00);

    frame(16'h8477, 16, 0, 9);
    mem_clr();
    chk("rstmid_stb", stb_cnt - b_stb, 0);
    chk("rstmid_ferr", ferr_cnt - b_ferr, 0);
    lread(7'h04, v);
    chk("rstmid_rf4", v, 8'h00);
    lread(7'h05, v);
    chk("rstmid_rf5", v, 8'h00);
    lcl_addr = 7'h04;
    frame(16'h8477, 16, 0, -1);
    chk_write("w8477", 7'h04, 8'h77);
    mem[4] = 8'h77;

    frame(16'h7F00, 16, 0, -1);
    chk("r7F_data", rd, 8'h00);
    chk("r7F_oedata", oe_all, 1);
    chk("r7F_oe_end", miso_oe, 0);
    chk("r7F_miso_end", miso, 0);

    sen = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    mem_clr();
    b_stb = stb_cnt;
    b_ferr = ferr_cnt;
    repeat (H) @(negedge clk);
    bits(16'h8633, 16, 0, -1);
    repeat (H) @(negedge clk);
    sen = 1;
    repeat (2 * H) @(negedge clk);
    chk("senlow_stb", stb_cnt - b_stb, 0);
    chk("senlow_ferr", ferr_cnt - b_ferr, 0);
    lcl_addr = 7'h06;
    frame(16'h8633, 16, 0, -1);
    chk_write("w8633", 7'h06, 8'h33);
    mem[6] = 8'h33;

    for (int k = 0; k < 40; k++) begin
      int kind, n;
      logic [6:0] a;
      logic [7:0] d;
      kind = $urandom_range(0, 9);
      a = 7'($urandom_range(0, 15));
      d = 8'($urandom);
      if (kind < 4) begin
        n = ($urandom_range(0, 1) == 0) ? 16 : $urandom_range(17, 20);
        lcl_addr = a;
        frame({1'b1, a, d}, n, 0, -1);
        chk_write("rnd_w", a, d);
        mem[a] = d;
      end else if (kind < 8) begin
        frame({1'b0, a, d}, 16, 0, -1);
        chk("rnd_r_data", rd, mem[a]);
        chk("rnd_r_oe", {oe_cmd, oe_all}, 2'b01);
        chk("rnd_r_stb", stb_cnt - b_stb, 0);
        chk("rnd_r_end", {miso_oe, miso}, 2'b00);
      end else begin
        n = $urandom_range(1, 15);
        frame({1'($urandom), a, d}, n, 0, -1);
        chk("rnd_ab_ferr", ferr_cnt - b_ferr, 1);
        chk("rnd_ab_stb", stb_cnt - b_stb, 0);
        chk("rnd_ab_oe", miso_oe, 0);
        lread(a, v);
        chk("rnd_ab_rf", v, mem[a]);
      end
    end

    for (int a = 0; a < 16; a++) begin
      lread(7'(a), v);
      chk("final_rf", v, mem[a]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
